// File: rtl/rsv_station_age_if.sv
// Dispatch, CDB snoop and issue handshake bundle for the age-ordered reservation station.
interface rsv_station_age_if #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 6,
  parameter int PL_W  = 32
);
  logic             disp_valid;
  logic             disp_ready;
  logic [PL_W-1:0]  disp_payload;
  logic [XLEN-1:0]  disp_rs1_data;
  logic [TAG_W-1:0] disp_rs1_tag;
  logic             disp_rs1_vld;
  logic [XLEN-1:0]  disp_rs2_data;
  logic [TAG_W-1:0] disp_rs2_tag;
  logic             disp_rs2_vld;

  logic             cdb_valid;
  logic [TAG_W-1:0] cdb_tag;
  logic [XLEN-1:0]  cdb_data;

  logic             iss_valid;
  logic             iss_ready;
  logic [PL_W-1:0]  iss_payload;
  logic [XLEN-1:0]  iss_rs1_data;
  logic [XLEN-1:0]  iss_rs2_data;

  modport slave (
    input  disp_valid, disp_payload, disp_rs1_data, disp_rs1_tag, disp_rs1_vld,
           disp_rs2_data, disp_rs2_tag, disp_rs2_vld,
           cdb_valid, cdb_tag, cdb_data, iss_ready,
    output disp_ready, iss_valid, iss_payload, iss_rs1_data, iss_rs2_data
  );

  modport master (
    output disp_valid, disp_payload, disp_rs1_data, disp_rs1_tag, disp_rs1_vld,
           disp_rs2_data, disp_rs2_tag, disp_rs2_vld,
           cdb_valid, cdb_tag, cdb_data, iss_ready,
    input  disp_ready, iss_valid, iss_payload, iss_rs1_data, iss_rs2_data
  );
endinterface

// File: rtl/rsv_station_age.sv
// Reservation station: CDB wake-up, oldest-ready select via an age matrix, registered issue slot.
module rsv_station_age #(
  parameter int DEPTH = 4,
  parameter int XLEN  = 32,
  parameter int TAG_W = 6,
  parameter int PL_W  = 32
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic                       flush,
  rsv_station_age_if.slave           bus,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       empty
);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int IDX_W = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  typedef struct packed {
    logic [PL_W-1:0]  payload;
    logic [XLEN-1:0]  rs1_data;
    logic [TAG_W-1:0] rs1_tag;
    logic             rs1_vld;
    logic [XLEN-1:0]  rs2_data;
    logic [TAG_W-1:0] rs2_tag;
    logic             rs2_vld;
  } entry_t;

  entry_t           entry_q [DEPTH];
  logic [DEPTH-1:0] older_q [DEPTH];  // older_q[i][j]: entry i was dispatched before entry j
  logic [DEPTH-1:0] valid_q;
  logic [CNT_W-1:0] count_q, count_d;
  logic             iss_valid_q;
  logic [PL_W-1:0]  iss_payload_q;
  logic [XLEN-1:0]  iss_rs1_q, iss_rs2_q;

  logic             disp_fire, iss_load;
  logic [IDX_W-1:0] free_idx, sel_idx;
  logic [DEPTH-1:0] cand, oldest;
  entry_t           disp_raw, disp_entry;

  // Captures a CDB broadcast into any still-pending operand whose tag matches.
  function automatic entry_t snoop(input entry_t e, input logic v,
                                   input logic [TAG_W-1:0] t, input logic [XLEN-1:0] d);
    snoop = e;
    if (v && !e.rs1_vld && e.rs1_tag == t) begin
      snoop.rs1_data = d;
      snoop.rs1_vld  = 1'b1;
    end
    if (v && !e.rs2_vld && e.rs2_tag == t) begin
      snoop.rs2_data = d;
      snoop.rs2_vld  = 1'b1;
    end
  endfunction

  assign bus.disp_ready = (count_q < DEPTH_C);
  assign disp_fire      = bus.disp_valid & bus.disp_ready;
  assign iss_load       = (~iss_valid_q | bus.iss_ready) & (|cand);

  assign disp_raw = '{payload:  bus.disp_payload,
                      rs1_data: bus.disp_rs1_data, rs1_tag: bus.disp_rs1_tag, rs1_vld: bus.disp_rs1_vld,
                      rs2_data: bus.disp_rs2_data, rs2_tag: bus.disp_rs2_tag, rs2_vld: bus.disp_rs2_vld};
  assign disp_entry = snoop(disp_raw, bus.cdb_valid, bus.cdb_tag, bus.cdb_data);

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    free_idx = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!valid_q[i]) free_idx = IDX_W'(i);
    end
  end

  // A candidate is oldest when no other candidate is older than it.
  always_comb begin
    cand    = '0;
    oldest  = '0;
    sel_idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      cand[i] = valid_q[i] & entry_q[i].rs1_vld & entry_q[i].rs2_vld;
    end
    for (int i = 0; i < DEPTH; i++) begin
      oldest[i] = cand[i];
      for (int j = 0; j < DEPTH; j++) begin
        if (j != i && cand[j] && older_q[j][i]) oldest[i] = 1'b0;
      end
    end
    for (int i = 0; i < DEPTH; i++) begin
      if (oldest[i]) sel_idx = IDX_W'(i);
    end
  end

  always_comb begin
    count_d = count_q;
    if (disp_fire && !iss_load)      count_d = count_q + CNT_W'(1);
    else if (!disp_fire && iss_load) count_d = count_q - CNT_W'(1);
  end

  // NOTE: sequential state is assigned with <= only, so every register samples pre-edge values.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      valid_q       <= '0;
      count_q       <= '0;
      iss_valid_q   <= 1'b0;
      iss_payload_q <= '0;
      iss_rs1_q     <= '0;
      iss_rs2_q     <= '0;
    end else if (flush) begin
      valid_q       <= '0;
      count_q       <= '0;
      iss_valid_q   <= 1'b0;
      iss_payload_q <= '0;
      iss_rs1_q     <= '0;
      iss_rs2_q     <= '0;
    end else begin
      count_q <= count_d;
      if (iss_load) valid_q[sel_idx] <= 1'b0;
      if (disp_fire) valid_q[free_idx] <= 1'b1;
      if (iss_load) begin
        iss_valid_q   <= 1'b1;
        iss_payload_q <= entry_q[sel_idx].payload;
        iss_rs1_q     <= entry_q[sel_idx].rs1_data;
        iss_rs2_q     <= entry_q[sel_idx].rs2_data;
      end else if (bus.iss_ready) begin
        iss_valid_q <= 1'b0;
      end
    end
  end

  // NOTE: entry contents and age bits are only ever read behind valid_q, so they carry no reset.
  always_ff @(posedge i_clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      entry_q[i] <= snoop(entry_q[i], bus.cdb_valid, bus.cdb_tag, bus.cdb_data);
    end
    if (disp_fire) begin
      entry_q[free_idx] <= disp_entry;
      older_q[free_idx] <= '0;
      for (int j = 0; j < DEPTH; j++) begin
        if (valid_q[j]) older_q[j][free_idx] <= 1'b1;
      end
    end
  end

  assign bus.iss_valid    = iss_valid_q;
  assign bus.iss_payload  = iss_payload_q;
  assign bus.iss_rs1_data = iss_rs1_q;
  assign bus.iss_rs2_data = iss_rs2_q;
  assign count            = count_q;
  assign empty            = (count_q == '0) & ~iss_valid_q;
endmodule
